// File: rtl/fpadd_pkg.sv
// ============================================================================
// Module : fpadd_pkg
// Brief  : Shared widths and operand-loader state encoding for the FP adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpadd_pkg;
    localparam int FP_WIDTH          = 32;
    localparam int BYTE_WIDTH        = 8;
    localparam int NUM_OPERAND_BYTES = 8;
    localparam int IDX_WIDTH         = $clog2(NUM_OPERAND_BYTES);

    typedef enum logic [0:0] {
        ST_LOAD    = 1'b0,
        ST_PRESENT = 1'b1
    } load_state_t;
endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : Synchronizes and debounces a raw push button; emits a 1-cycle pulse
//          on each accepted press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press_pulse
);
    // A width of at least one bit keeps DEBOUNCE_CYCLES == 1 legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            if (r_sync2 != r_stable) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press_pulse = r_press;
endmodule

`default_nettype wire

// File: rtl/fp_operand_loader.sv
// ============================================================================
// Module : fp_operand_loader
// Brief  : Loads two 32-bit operands byte by byte from switches and presents
//          the pair to the FP adder over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_operand_loader
    import fpadd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] switches,
    input  logic                  load_btn,
    input  logic                  operands_ready,
    output logic [FP_WIDTH-1:0]   reg_A,
    output logic [FP_WIDTH-1:0]   reg_B,
    output logic                  operands_valid,
    output logic [IDX_WIDTH-1:0]  byte_idx
);
    load_state_t           r_state;
    logic [FP_WIDTH-1:0]   r_reg_a;
    logic [FP_WIDTH-1:0]   r_reg_b;
    logic                  r_valid;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  w_press;
    logic [4:0]            w_msb;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_debounce (
        .clk           (clk),
        .rst           (reset),
        .i_btn         (load_btn),
        .o_press_pulse (w_press)
    );

    // Byte 0 of each operand lands in the most significant slice.
    assign w_msb = 5'd31 - {r_idx[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_reg_a <= '0;
            r_reg_b <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_press) begin
                        if (!r_idx[2]) begin
                            r_reg_a[w_msb -: BYTE_WIDTH] <= switches;
                        end else begin
                            r_reg_b[w_msb -: BYTE_WIDTH] <= switches;
                        end
                        if (r_idx == IDX_WIDTH'(NUM_OPERAND_BYTES - 1)) begin
                            r_idx   <= '0;
                            r_valid <= 1'b1;
                            r_state <= ST_PRESENT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    // Presses here are intentionally dropped, not queued.
                    if (r_valid && operands_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign reg_A          = r_reg_a;
    assign reg_B          = r_reg_b;
    assign operands_valid = r_valid;
    assign byte_idx       = r_idx;
endmodule

`default_nettype wire

// File: tb/tb_fp_operand_loader.sv
// ============================================================================
// Module : tb_fp_operand_loader
// Brief  : Self-checking bench for fp_operand_loader with a byte-load model and
//          an operand-pair scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_operand_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  switches = 8'h00;
    logic        load_btn = 1'b0;
    logic        operands_ready = 1'b0;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic        operands_valid;
    logic [2:0]  byte_idx;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_idx;
    logic        m_valid;
    logic [63:0] sb[$];

    fp_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .switches       (switches),
        .load_btn       (load_btn),
        .operands_ready (operands_ready),
        .reg_A          (reg_A),
        .reg_B          (reg_B),
        .operands_valid (operands_valid),
        .byte_idx       (byte_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_a = 32'h0; m_b = 32'h0; m_idx = 3'd0; m_valid = 1'b0;
    endtask

    task automatic model_press(input logic [7:0] val);
        if (!m_valid) begin
            if (m_idx < 3'd4) m_a[31 - 8*int'(m_idx[1:0]) -: 8] = val;
            else              m_b[31 - 8*int'(m_idx[1:0]) -: 8] = val;
            if (m_idx == 3'd7) begin
                m_idx = 3'd0;
                m_valid = 1'b1;
                sb.push_back({m_a, m_b});
            end else begin
                m_idx = m_idx + 3'd1;
            end
        end
    endtask

    // Button held for 'hold' cycles; the byte lands exactly after edge k+7.
    task automatic press_byte(input logic [7:0] val, input int hold);
        switches = val;
        load_btn = 1'b1;
        repeat (7) tick();
        total++;
        if (byte_idx !== m_idx) begin
            bad++; $display("FAIL early_idx: got %0d want %0d", byte_idx, m_idx);
        end
        tick();
        model_press(val);
        total++;
        if ({reg_A, reg_B, byte_idx, operands_valid} !== {m_a, m_b, m_idx, m_valid}) begin
            bad++;
            $display("FAIL press_write: got A=%h B=%h idx=%0d v=%b want A=%h B=%h idx=%0d v=%b",
                     reg_A, reg_B, byte_idx, operands_valid, m_a, m_b, m_idx, m_valid);
        end
        if (hold > 8) repeat (hold - 8) tick();
        load_btn = 1'b0;
        repeat (8) tick();
        total++;
        if ({reg_A, reg_B, byte_idx} !== {m_a, m_b, m_idx}) begin
            bad++;
            $display("FAIL release_nowrite: got A=%h B=%h idx=%0d want A=%h B=%h idx=%0d",
                     reg_A, reg_B, byte_idx, m_a, m_b, m_idx);
        end
    endtask

    task automatic handshake();
        logic [63:0] exp;
        total++;
        if (operands_valid !== 1'b1) begin
            bad++; $display("FAIL hs_valid_before: got %b want 1", operands_valid);
        end
        operands_ready = 1'b1;
        tick();
        operands_ready = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL hs_scoreboard: got empty queue want one pair");
        end else begin
            exp = sb.pop_front();
            if ({reg_A, reg_B} !== exp) begin
                bad++; $display("FAIL hs_pair: got %h want %h", {reg_A, reg_B}, exp);
            end
        end
        m_valid = 1'b0;
        total++;
        if (operands_valid !== 1'b0) begin
            bad++; $display("FAIL hs_valid_after: got %b want 0", operands_valid);
        end
    endtask

    task automatic load_eight(input logic [63:0] bytes);
        logic [63:0] v;
        v = bytes;
        for (int i = 0; i < 8; i++) press_byte(v[63 - 8*i -: 8], 9);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        total++;
        if ({reg_A, reg_B, operands_valid, byte_idx} !== 68'h0) begin
            bad++;
            $display("FAIL reset_state: got A=%h B=%h v=%b idx=%0d want all 0",
                     reg_A, reg_B, operands_valid, byte_idx);
        end
    endtask

    task automatic test_full_load();
        load_eight(64'h6b64b235_6ac49214);
        total++;
        if ({reg_A, reg_B, operands_valid, byte_idx} !== {32'h6b64b235, 32'h6ac49214, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL full_load: got A=%h B=%h v=%b idx=%0d want A=6b64b235 B=6ac49214 v=1 idx=0",
                     reg_A, reg_B, operands_valid, byte_idx);
        end
        handshake();
    endtask

    task automatic test_debounce();
        switches = 8'hee;
        load_btn = 1'b1;
        repeat (3) tick();
        load_btn = 1'b0;
        repeat (12) tick();
        total++;
        if ({reg_A, byte_idx} !== {m_a, m_idx}) begin
            bad++;
            $display("FAIL glitch: got A=%h idx=%0d want A=%h idx=%0d", reg_A, byte_idx, m_a, m_idx);
        end
        press_byte(8'h5a, 8);
        press_byte(8'hc3, 100);
    endtask

    task automatic test_backpressure();
        for (int i = 2; i < 8; i++) press_byte(8'(8'h10 + i), 9);
        operands_ready = 1'b0;
        repeat (50) tick();
        press_byte(8'hff, 9);
        press_byte(8'h00, 9);
        total++;
        if ({operands_valid, byte_idx} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL backpressure: got v=%b idx=%0d want v=1 idx=0", operands_valid, byte_idx);
        end
        // Press pulse lands on the handshake edge and must be dropped.
        switches = 8'h99;
        load_btn = 1'b1;
        repeat (7) tick();
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL coincide_sb: got empty queue want one pair");
        end else begin
            operands_ready = 1'b1;
            tick();
            operands_ready = 1'b0;
            if ({reg_A, reg_B} !== sb.pop_front()) begin
                bad++; $display("FAIL coincide_pair: got %h/%h want model pair", reg_A, reg_B);
            end
        end
        m_valid = 1'b0;
        load_btn = 1'b0;
        repeat (8) tick();
        total++;
        if ({reg_A, reg_B, operands_valid, byte_idx} !== {m_a, m_b, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL coincide_drop: got A=%h B=%h v=%b idx=%0d want A=%h B=%h v=0 idx=0",
                     reg_A, reg_B, operands_valid, byte_idx, m_a, m_b);
        end
    endtask

    task automatic test_ready_preasserted();
        operands_ready = 1'b1;
        for (int i = 0; i < 7; i++) press_byte(8'(8'h21 * (i + 1)), 9);
        switches = 8'h7e;
        load_btn = 1'b1;
        repeat (8) tick();
        model_press(8'h7e);
        total++;
        if (operands_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL pre_ready_rise: got v=%b q=%0d want v=1 q=1", operands_valid, sb.size());
        end else if ({reg_A, reg_B} !== sb.pop_front()) begin
            bad++; $display("FAIL pre_ready_pair: got %h/%h want model pair", reg_A, reg_B);
        end
        tick();
        m_valid = 1'b0;
        total++;
        if (operands_valid !== 1'b0) begin
            bad++; $display("FAIL pre_ready_pulse: got v=%b want 0", operands_valid);
        end
        load_btn = 1'b0;
        repeat (8) tick();
        press_byte(8'hab, 9);
        total++;
        if (reg_A[23:0] !== m_a[23:0] || reg_A[31:24] !== 8'hab) begin
            bad++; $display("FAIL pre_ready_retain: got A=%h want A=%h", reg_A, m_a);
        end
        operands_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) press_byte(8'(8'h31 + i), 9);
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        total++;
        if ({reg_A, reg_B, operands_valid, byte_idx} !== 68'h0) begin
            bad++;
            $display("FAIL reset_mid: got A=%h B=%h v=%b idx=%0d want all 0",
                     reg_A, reg_B, operands_valid, byte_idx);
        end
        load_eight(64'hdeadbeef_01234567);
        handshake();
        load_eight(64'h3f800000_c0000000);
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        if (sb.size() > 0) void'(sb.pop_front());
        total++;
        if ({operands_valid, byte_idx, reg_A, reg_B} !== 68'h0) begin
            bad++;
            $display("FAIL reset_present: got v=%b idx=%0d A=%h B=%h want all 0",
                     operands_valid, byte_idx, reg_A, reg_B);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_load();
        test_debounce();
        test_backpressure();
        test_ready_preasserted();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fp_operand_loader.md
# fp_operand_loader

Board-side operand entry for the FP adder: the input counterpart to the result display path. Collects two 32-bit IEEE-754 operands byte by byte from the 8 board switches, one debounced button press per byte. Presents the completed operand pair to the adder over a valid/ready handshake, replacing hardwired operand constants in the system top. Exposes load progress for the LEDs.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be ≥1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; the already-debounced system reset.
- switches  in  8  byte value to load; sampled only on the accepted-press cycle; must be static around the press.
- load_btn  in  1  raw asynchronous push button, active-high.
- operands_ready  in  1  adder side accepts the operand pair.
- reg_A  out  32  operand A; reset 32'h0.
- reg_B  out  32  operand B; reset 32'h0.
- operands_valid  out  1  pair complete, awaiting acceptance; reset 0.
- byte_idx  out  3  index of the next byte to load (0–7); reset 0.

## Operation
- Button path: 2-flop synchronizer, then debounce. A counter increments each cycle the synchronized level differs from the stable level and clears on any cycle they match. When it differs with count == DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears. A registered rising-edge detect on the stable level gives a 1-cycle press_pulse. Releases produce no pulse.
- Byte order: idx 0..3 → reg_A[31:24], [23:16], [15:8], [7:0]; idx 4..7 → reg_B[31:24] … [7:0]. Slice written = 31-8*(idx mod 4) downto 24-8*(idx mod 4).
- FSM states: LOAD, PRESENT.
  - LOAD: on press_pulse, write switches into the slice selected by byte_idx. If byte_idx==7, byte_idx ← 0, operands_valid ← 1, go PRESENT; else byte_idx ← byte_idx+1.
  - PRESENT: operands_valid held 1; reg_A/reg_B frozen. A press_pulse is dropped, with no write and no queueing. On operands_valid & operands_ready: operands_valid ← 0, go LOAD.
- After a transfer, reg_A/reg_B keep their values. The next load overwrites them slice by slice. The consumer must latch at the handshake.
- Reset, including mid-load or in PRESENT: state LOAD, byte_idx 0, operands_valid 0, reg_A/reg_B 0. Synchronizer, debounce counter, stable level and press_pulse also clear. A button held through reset deasserting is accepted as a new press after debounce.

## Timing
- Raw load_btn rises and is held; edge k is the first to sample it. The stable level changes at edge k+1+DEBOUNCE_CYCLES, press_pulse is high after edge k+2+DEBOUNCE_CYCLES, and the byte plus byte_idx update after edge k+3+DEBOUNCE_CYCLES.
- If the raw level drops before the count completes, the counter clears and there is no pulse. Glitches shorter than DEBOUNCE_CYCLES are filtered.
- operands_valid rises at the same edge that writes byte 7.
- Handshake completes at the first edge where valid & ready are both high. operands_valid is low the next cycle. Ready may be high in advance, giving a 1-cycle valid pulse.
- A press_pulse in the same cycle as handshake completion is dropped because the state is still PRESENT.
- Ready asserted while in LOAD has no effect.

## Structure
- Shared package fpadd_pkg: FP_WIDTH=32, BYTE_WIDTH=8, NUM_OPERAND_BYTES=8, the LOAD/PRESENT state encoding. Debounce counter width is derived with $clog2(DEBOUNCE_CYCLES).
- One sub-module: button_debounce, containing the synchronizer, debounce counter and edge detect, with parameter DEBOUNCE_CYCLES. It outputs press_pulse and is reusable for the reset button.
- Top level holds the FSM, byte_idx counter and operand registers.

## Test plan
Use DEBOUNCE_CYCLES=4 for all scenarios.
- Full load: eight clean presses with switches 6b,64,b2,35,6a,c4,92,14 → reg_A=32'h6b64b235, reg_B=32'h6ac49214, operands_valid=1, byte_idx=0. Ready high for 1 cycle → valid 0, state LOAD.
- Debounce: 3-cycle glitch on load_btn → no write, byte_idx unchanged. A held press → byte written exactly after edge k+7. Holding the button 100 cycles → only one byte written. Release → no write.
- Backpressure: ready low for 50 cycles in PRESENT, with two presses and changing switches → valid stays 1, reg_A/reg_B unchanged, byte_idx 0. Press coinciding with the ready cycle → dropped.
- Ready pre-asserted: ready tied high → valid is high for exactly 1 cycle after byte 7. The next press writes reg_A[31:24] only, and reg_A[23:0] and reg_B are retained.
- Reset mid-operation: reset after 5 bytes → all outputs 0. A fresh 8-byte load then completes normally. Reset while in PRESENT → valid 0 the next cycle.
